// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CHUNKED_ADDER_OVERFLOW_EN.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             cout_reg;

    logic             in_xfer;
    logic             busy;
    logic             last_slice;
    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;
    logic [CHUNK-1:0] s_cur;
    logic             c_cur;

    assign in_ready   = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    assign out_valid  = (state_reg == ST_DONE);
    assign in_xfer    = in_valid && in_ready;
    assign busy       = (state_reg == ST_BUSY);
    assign last_slice = (idx_reg == LAST_IDX);

    // Slice selection as a constant-index mux so every select is a fixed part-select.
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_cur = a_reg[i*CHUNK +: CHUNK];
                b_cur = b_reg[i*CHUNK +: CHUNK];
            end
        end
    end

    assign {c_cur, s_cur} = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_xfer) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (last_slice) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (in_xfer) begin
                    state_next = ST_BUSY;
                end else if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Subtraction is folded in at capture: invert b and seed the carry with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (in_xfer) begin
                a_reg     <= a;
                b_reg     <= b ^ {WIDTH{sub}};
                carry_reg <= sub;
                idx_reg   <= '0;
            end else if (busy) begin
                carry_reg <= c_cur;
                idx_reg   <= last_slice ? '0 : idx_reg + 1'b1;
                if (last_slice) begin
                    cout_reg <= c_cur;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
            logic [CHUNK-1:0] res_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_reg <= '0;
                end else if (busy && (idx_reg == IDXW'(gi))) begin
                    res_reg <= s_cur;
                end
            end

            assign sum[gi*CHUNK +: CHUNK] = res_reg;
        end
    endgenerate

    assign sum[WIDTH] = cout_reg;

`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic ovf_reg;
    logic c_into_msb;

    // Carry into the MSB recovered from the MSB's own sum bit.
    assign c_into_msb = a_cur[CHUNK-1] ^ b_cur[CHUNK-1] ^ s_cur[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (busy && last_slice) begin
            ovf_reg <= c_into_msb ^ c_cur;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=8, CHUNK=4) against an arithmetic reference model.
module tb_chunked_adder;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int NC = W / C;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   sum;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic         ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carry-out of a subtraction means "no borrow", i.e. x >= y.
    function automatic logic [W:0] model_sum(input int x, input int y, input bit s);
        int r;
        if (!s) begin
            r = x + y;
        end else begin
            r = x - y;
            if (r < 0) r += (1 << W);
            if (x >= y) r += (1 << W);
        end
        return (W+1)'(r);
    endfunction

    function automatic bit model_ovf(input int x, input int y, input bit s);
        int sx, sy, r;
        sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        r  = s ? sx - sy : sx + sy;
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    task automatic do_op(input int x, input int y, input bit s, input int stall);
        int         lat;
        logic [W:0] exp;
        logic [W:0] held;
        exp = model_sum(x, y, s);
        check("in_ready_before", in_ready, 1);
        a         = W'(x);
        b         = W'(y);
        sub       = s;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        sub      = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, NC);
        check("sum", sum, exp);
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        check("ovf", ovf, model_ovf(x, y, s));
`endif
        held = sum;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            check("hold_in_ready", in_ready, 0);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drained", out_valid, 0);
        $display("op a=%0d b=%0d sub=%0d stall=%0d sum=%h lat=%0d", x, y, s, stall, held, lat);
    endtask

    initial begin
        int pa[3];
        int k, got, last, cyc;
        bit xfer;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        check("rst_ovf", ovf, 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed arithmetic
        do_op(200, 100, 1'b0, 0);
        check("add_200_100", sum, 9'h12C);
        do_op(5, 7, 1'b1, 0);
        check("sub_5_7", sum, 9'h0FE);
        do_op(7, 5, 1'b1, 0);
        check("sub_7_5", sum, 9'h102);

        // Held result with a competing operand offer
        do_op(33, 44, 1'b0, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_extra_accept", out_valid, 0);
        end
        check("idle_in_ready", in_ready, 1);

        // Back-to-back stream without bubbles
        pa = '{1, 2, 3};
        k = 0; got = 0; last = 0; cyc = 0;
        out_ready = 1'b1;
        a = W'(pa[0]); b = W'(pa[0]); sub = 1'b0; in_valid = 1'b1;
        while (got < 3 && cyc < 40) begin
            if (out_valid) begin
                check("b2b_sum", sum, model_sum(pa[got], pa[got], 1'b0));
                if (got > 0) check("b2b_gap", cyc - last, NC + 1);
                $display("b2b result %0d sum=%h cycle=%0d", got, sum, cyc);
                last = cyc;
                got++;
            end
            xfer = in_valid && in_ready;
            tick();
            cyc++;
            if (xfer) begin
                k++;
                if (k < 3) begin
                    a = W'(pa[k]);
                    b = W'(pa[k]);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", got, 3);
        in_valid = 1'b0;
        tick();
        check("b2b_drained", out_valid, 0);

        // Asynchronous reset after the first slice
        a = W'(200); b = W'(100); sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_sum", sum, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_no_valid", out_valid, 0);
        end
        $display("reset mid-busy applied");
        do_op(1, 1, 1'b0, 0);
        check("post_rst_sum", sum, 9'h002);

`ifdef CHUNKED_ADDER_OVERFLOW_EN
        do_op(8'h7F, 8'h01, 1'b0, 0);
        check("ovf_pos_sum", sum, 9'h080);
        check("ovf_pos", ovf, 1);
        do_op(8'h80, 8'h01, 1'b1, 0);
        check("ovf_neg_sum", sum[W-1:0], 8'h7F);
        check("ovf_neg", ovf, 1);
        do_op(3, 4, 1'b0, 0);
        check("ovf_none", ovf, 0);
`endif

        // Randomized operations with random result stalls
        for (int n = 0; n < 40; n++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
